// File: rtl/weight_bram_reader.sv
// Weight BRAM read sequencer: issues one or two BRAM reads per request and presents registered words.
// Optional sticky address-wrap flag output is enabled with `define WEIGHT_READER_WRAP_FLAG_EN.
module weight_bram_reader #(
   parameter int unsigned DATA_WIDTH         = 1280,
   parameter int unsigned BRAM_ADDRESS_WIDTH = 12,
   parameter int unsigned BRAM_DEPTH         = 4096
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          address_reset,
   input  logic                          read_en,
   input  logic                          read_len,
   output logic                          data_valid,
   output logic [DATA_WIDTH-1:0]         weight_a,
   output logic [DATA_WIDTH-1:0]         weight_b,
   output logic                          busy,
   output logic                          bram_en_a,
   output logic                          bram_en_b,
   output logic [BRAM_ADDRESS_WIDTH-1:0] bram_addr_a,
   output logic [BRAM_ADDRESS_WIDTH-1:0] bram_addr_b,
   input  logic [DATA_WIDTH-1:0]         bram_dout_a,
   input  logic [DATA_WIDTH-1:0]         bram_dout_b
`ifdef WEIGHT_READER_WRAP_FLAG_EN
   ,
   output logic                          addr_wrapped
`endif
);

   localparam int unsigned AW = BRAM_ADDRESS_WIDTH;
   localparam logic [AW-1:0] LAST_ADDR = AW'(BRAM_DEPTH - 1);

   if (BRAM_DEPTH < 1 || 64'(BRAM_DEPTH) > (64'd1 << AW)) begin : g_depth_check
      $error("BRAM_DEPTH must be in 1..2**BRAM_ADDRESS_WIDTH");
   end

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ISSUE   = 2'd1,
      CAPTURE = 2'd2,
      VALID   = 2'd3
   } state_t;

   state_t        state;
   logic [AW-1:0] ptr;
   logic          len_q;
   logic [AW-1:0] ptr_p1;
   logic [AW-1:0] ptr_p2;
   logic [AW-1:0] ptr_next;

   // Modulo-depth increments; depth need not be a power of two.
   always_comb begin
      ptr_p1   = (ptr == LAST_ADDR)    ? '0 : ptr + AW'(1);
      ptr_p2   = (ptr_p1 == LAST_ADDR) ? '0 : ptr_p1 + AW'(1);
      ptr_next = len_q ? ptr_p2 : ptr_p1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         ptr         <= '0;
         len_q       <= 1'b0;
         data_valid  <= 1'b0;
         busy        <= 1'b0;
         bram_en_a   <= 1'b0;
         bram_en_b   <= 1'b0;
         bram_addr_a <= '0;
         bram_addr_b <= '0;
         weight_a    <= '0;
         weight_b    <= '0;
      end else if (address_reset) begin
         // Drops any in-flight request; captured weights are left untouched.
         state       <= IDLE;
         ptr         <= '0;
         data_valid  <= 1'b0;
         busy        <= 1'b0;
         bram_en_a   <= 1'b0;
         bram_en_b   <= 1'b0;
         bram_addr_a <= '0;
         bram_addr_b <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               data_valid <= 1'b0;
               if (read_en) begin
                  // Outputs are registered, so the ISSUE drive is set up on entry.
                  state       <= ISSUE;
                  len_q       <= read_len;
                  busy        <= 1'b1;
                  bram_en_a   <= 1'b1;
                  bram_en_b   <= read_len;
                  bram_addr_a <= ptr;
                  bram_addr_b <= ptr_p1;
               end
            end
            ISSUE: begin
               state       <= CAPTURE;
               ptr         <= ptr_next;
               bram_en_a   <= 1'b0;
               bram_en_b   <= 1'b0;
               bram_addr_a <= '0;
               bram_addr_b <= '0;
            end
            CAPTURE: begin
               state      <= VALID;
               data_valid <= 1'b1;
               weight_a   <= bram_dout_a;
               if (len_q) begin
                  weight_b <= bram_dout_b;
               end
            end
            VALID: begin
               state      <= IDLE;
               data_valid <= 1'b0;
               busy       <= 1'b0;
            end
            default: begin
               state      <= IDLE;
               data_valid <= 1'b0;
               busy       <= 1'b0;
            end
         endcase
      end
   end

`ifdef WEIGHT_READER_WRAP_FLAG_EN
   logic wrap_step;

   // A step wraps if it starts on the last address or passes through it.
   always_comb begin
      wrap_step = (ptr == LAST_ADDR) || (len_q && (ptr_p1 == LAST_ADDR));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_wrapped <= 1'b0;
      end else if (address_reset) begin
         addr_wrapped <= 1'b0;
      end else if (state == ISSUE && wrap_step) begin
         addr_wrapped <= 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_weight_bram_reader.sv
// Directed self-checking bench for weight_bram_reader with a small 8-deep synchronous BRAM model.
module tb_weight_bram_reader;

   localparam int unsigned DW    = 40;
   localparam int unsigned AW    = 3;
   localparam int unsigned DEPTH = 8;

   logic          clk;
   logic          rst_n;
   logic          address_reset;
   logic          read_en;
   logic          read_len;
   logic          data_valid;
   logic [DW-1:0] weight_a;
   logic [DW-1:0] weight_b;
   logic          busy;
   logic          bram_en_a;
   logic          bram_en_b;
   logic [AW-1:0] bram_addr_a;
   logic [AW-1:0] bram_addr_b;
   logic [DW-1:0] bram_dout_a;
   logic [DW-1:0] bram_dout_b;
`ifdef WEIGHT_READER_WRAP_FLAG_EN
   logic          addr_wrapped;
`endif

   int unsigned   n_checks;
   int unsigned   n_fail;
   int unsigned   model_ptr;
   logic [DW-1:0] exp_wb;
   int unsigned   dv_count;

   weight_bram_reader #(
      .DATA_WIDTH        (DW),
      .BRAM_ADDRESS_WIDTH(AW),
      .BRAM_DEPTH        (DEPTH)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .address_reset(address_reset),
      .read_en      (read_en),
      .read_len     (read_len),
      .data_valid   (data_valid),
      .weight_a     (weight_a),
      .weight_b     (weight_b),
      .busy         (busy),
      .bram_en_a    (bram_en_a),
      .bram_en_b    (bram_en_b),
      .bram_addr_a  (bram_addr_a),
      .bram_addr_b  (bram_addr_b),
      .bram_dout_a  (bram_dout_a),
      .bram_dout_b  (bram_dout_b)
`ifdef WEIGHT_READER_WRAP_FLAG_EN
      ,
      .addr_wrapped (addr_wrapped)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Word 0 is 0xA5 replicated; word n>0 is byte (0x30+n) replicated.
   function automatic logic [DW-1:0] mem_word(input int unsigned a);
      logic [7:0] b;
      if (a == 0) b = 8'hA5;
      else        b = 8'h30 + 8'(a);
      return {5{b}};
   endfunction

   always @(posedge clk) begin
      if (bram_en_a) bram_dout_a <= mem_word(32'(bram_addr_a));
      if (bram_en_b) bram_dout_b <= mem_word(32'(bram_addr_b));
   end

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One request from IDLE at the model pointer, checked cycle by cycle.
   task automatic req(input logic len);
      int unsigned a;
      int unsigned b;
      a = model_ptr;
      b = (a + 1) % DEPTH;
      read_en  = 1'b1;
      read_len = len;
      tick();
      read_en = 1'b0;
      check("issue_en_a", 64'(bram_en_a), 64'd1);
      check("issue_addr_a", 64'(bram_addr_a), 64'(a));
      check("issue_en_b", 64'(bram_en_b), 64'(len));
      if (len) check("issue_addr_b", 64'(bram_addr_b), 64'(b));
      check("issue_busy", 64'(busy), 64'd1);
      check("issue_dv", 64'(data_valid), 64'd0);
      tick();
      check("capture_dv", 64'(data_valid), 64'd0);
      check("capture_en_a", 64'(bram_en_a), 64'd0);
      tick();
      if (len) exp_wb = mem_word(b);
      check("valid_dv", 64'(data_valid), 64'd1);
      check("valid_weight_a", 64'(weight_a), 64'(mem_word(a)));
      check("valid_weight_b", 64'(weight_b), 64'(exp_wb));
      tick();
      check("idle_dv", 64'(data_valid), 64'd0);
      check("idle_busy", 64'(busy), 64'd0);
      check("idle_weight_a_hold", 64'(weight_a), 64'(mem_word(a)));
      model_ptr = (a + (len ? 2 : 1)) % DEPTH;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      n_checks      = 0;
      n_fail        = 0;
      model_ptr     = 0;
      exp_wb        = '0;
      rst_n         = 1'b0;
      address_reset = 1'b0;
      read_en       = 1'b0;
      read_len      = 1'b0;
      bram_dout_a   = '0;
      bram_dout_b   = '0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_dv", 64'(data_valid), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_en_a", 64'(bram_en_a), 64'd0);
      check("rst_en_b", 64'(bram_en_b), 64'd0);
      check("rst_weight_a", 64'(weight_a), 64'd0);
      check("rst_weight_b", 64'(weight_b), 64'd0);
`ifdef WEIGHT_READER_WRAP_FLAG_EN
      check("rst_wrapped", 64'(addr_wrapped), 64'd0);
`endif
      rst_n = 1'b1;
      tick();

      // Single reads at 0 and 1, then paired reads at 2/3 and 4/5.
      req(1'b0);
      req(1'b0);
      req(1'b1);
      req(1'b1);
      check("ptr_after_pair", 64'(model_ptr), 64'd6);
      req(1'b0);
`ifdef WEIGHT_READER_WRAP_FLAG_EN
      check("wrapped_before", 64'(addr_wrapped), 64'd0);
`endif
      // Paired read at 7 wraps to 0 and leaves the pointer at 1.
      req(1'b1);
`ifdef WEIGHT_READER_WRAP_FLAG_EN
      check("wrapped_after", 64'(addr_wrapped), 64'd1);
`endif

      // read_en held high six cycles: one request, then a second after VALID.
      dv_count = 0;
      read_en  = 1'b1;
      read_len = 1'b0;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (i < 4 && data_valid) dv_count++;
         if (i == 4) begin
            check("held_second_en_a", 64'(bram_en_a), 64'd1);
            check("held_second_addr", 64'(bram_addr_a), 64'd2);
         end
      end
      read_en = 1'b0;
      check("held_dv_count", 64'(dv_count), 64'd1);
      tick();
      check("held_second_dv", 64'(data_valid), 64'd1);
      check("held_second_weight_a", 64'(weight_a), 64'(mem_word(2)));
      tick();
      model_ptr = 3;

      // address_reset during CAPTURE drops the request and holds the weights.
      read_en  = 1'b1;
      read_len = 1'b1;
      tick();
      read_en = 1'b0;
      check("ar_issue_addr_b", 64'(bram_addr_b), 64'd4);
      tick();
      address_reset = 1'b1;
      tick();
      address_reset = 1'b0;
      check("ar_dv", 64'(data_valid), 64'd0);
      check("ar_busy", 64'(busy), 64'd0);
      check("ar_weight_a_hold", 64'(weight_a), 64'(mem_word(2)));
      check("ar_weight_b_hold", 64'(weight_b), 64'(exp_wb));
`ifdef WEIGHT_READER_WRAP_FLAG_EN
      check("ar_wrapped_clear", 64'(addr_wrapped), 64'd0);
`endif
      tick();
      check("ar_dv_after", 64'(data_valid), 64'd0);
      model_ptr = 0;
      req(1'b0);

      // address_reset together with read_en: request is dropped, pointer to 0.
      read_en       = 1'b1;
      address_reset = 1'b1;
      tick();
      read_en       = 1'b0;
      address_reset = 1'b0;
      check("arre_busy", 64'(busy), 64'd0);
      check("arre_en_a", 64'(bram_en_a), 64'd0);
      dv_count = 0;
      for (int i = 0; i < 3; i++) begin
         tick();
         if (data_valid) dv_count++;
      end
      check("arre_dv_count", 64'(dv_count), 64'd0);
      model_ptr = 0;
      req(1'b1);

      // rst_n pulse during ISSUE aborts the request.
      read_en  = 1'b1;
      read_len = 1'b1;
      tick();
      read_en = 1'b0;
      check("rstmid_busy_before", 64'(busy), 64'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check("rstmid_busy", 64'(busy), 64'd0);
      check("rstmid_en_a", 64'(bram_en_a), 64'd0);
      check("rstmid_en_b", 64'(bram_en_b), 64'd0);
      check("rstmid_addr_a", 64'(bram_addr_a), 64'd0);
      check("rstmid_addr_b", 64'(bram_addr_b), 64'd0);
      check("rstmid_dv", 64'(data_valid), 64'd0);
      check("rstmid_weight_a", 64'(weight_a), 64'd0);
      check("rstmid_weight_b", 64'(weight_b), 64'd0);
      exp_wb = '0;
      @(negedge clk);
      rst_n = 1'b1;
      dv_count = 0;
      for (int i = 0; i < 4; i++) begin
         tick();
         if (data_valid) dv_count++;
      end
      check("rstmid_dv_count", 64'(dv_count), 64'd0);
      model_ptr = 0;
      req(1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/weight_bram_reader.md
WEIGHT_BRAM_READER -- requirements
Module: weight_bram_reader

Interface
REQ-001 Parameter DATA_WIDTH, default 1280, is the width of one BRAM word (5 bits x 256 MACs).
REQ-002 Parameter BRAM_ADDRESS_WIDTH, default 12, is the BRAM address width.
REQ-003 Parameter BRAM_DEPTH, default 4096, is the number of valid words; addresses run 0..BRAM_DEPTH-1.
REQ-004 clk  input  1  the single clock; all logic SHALL be rising-edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 address_reset  input  1  synchronous request to return the read pointer to 0.
REQ-007 read_en  input  1  read request from the weight-load controller.
REQ-008 read_len  input  1  request length: 0 = port A only, 1 = ports A and B.
REQ-009 data_valid  output  1  one-cycle pulse: weight_a/weight_b hold the requested words.
REQ-010 weight_a, weight_b  output  DATA_WIDTH each  registered read data.
REQ-011 busy  output  1  high whenever the FSM is not IDLE.
REQ-012 bram_en_a, bram_en_b  output  1 each  BRAM port enables.
REQ-013 bram_addr_a, bram_addr_b  output  BRAM_ADDRESS_WIDTH each  BRAM port addresses.
REQ-014 bram_dout_a, bram_dout_b  input  DATA_WIDTH each  BRAM read data, valid one cycle after the enable.

Function
REQ-015 The FSM SHALL have states IDLE, ISSUE, CAPTURE, VALID.
- IDLE -> ISSUE when read_en=1; latch read_len into len_q.
- ISSUE -> CAPTURE, CAPTURE -> VALID, VALID -> IDLE unconditionally.
REQ-016 In ISSUE the block SHALL drive these signals, and drive them nowhere else:
- bram_en_a=1, bram_addr_a=ptr.
- bram_en_b=len_q, bram_addr_b=(ptr+1) mod BRAM_DEPTH.
REQ-017 At the end of ISSUE, ptr SHALL advance by 1 (len_q=0) or 2 (len_q=1), modulo BRAM_DEPTH.
REQ-018 In CAPTURE, weight_a SHALL load bram_dout_a; weight_b SHALL load bram_dout_b if len_q=1, else it SHALL hold.
REQ-019 data_valid SHALL be 1 only in VALID.
- Latency from read_en sampled in IDLE at cycle N: data_valid=1 in cycle N+3.
REQ-020 weight_a/weight_b SHALL hold their value from VALID until the next CAPTURE.
REQ-021 read_en outside IDLE SHALL be ignored: a held-high read_en while waiting is one request, not several.
- read_en high in the cycle after VALID SHALL start a new request.
REQ-022 Wrap-around:
- ptr=BRAM_DEPTH-1 with len_q=1 SHALL read addresses BRAM_DEPTH-1 and 0, leaving ptr=1.
- ptr=BRAM_DEPTH-1 with len_q=0 SHALL leave ptr=0.
REQ-023 address_reset=1 SHALL take priority in any state:
- ptr<=0 and FSM<=IDLE next cycle; any in-flight request is dropped with no data_valid.
- weight_a/weight_b hold.
REQ-024 address_reset and read_en in the same cycle SHALL drop the request.

Reset
REQ-025 On rst_n=0, asynchronously:
- FSM=IDLE, ptr=0, len_q=0.
- data_valid=0, busy=0, bram_en_a=0, bram_en_b=0, bram_addr_a=0, bram_addr_b=0.
- weight_a=0, weight_b=0.
REQ-026 Reset asserted mid-request SHALL abort the request; no data_valid SHALL follow the release of rst_n.

Configuration
REQ-027 Macro WEIGHT_READER_WRAP_FLAG_EN, when defined, SHALL add output addr_wrapped (1 bit).
- addr_wrapped sets when a ptr advance crosses BRAM_DEPTH-1 -> 0.
- It is sticky until address_reset or rst_n.
REQ-028 Without WEIGHT_READER_WRAP_FLAG_EN, the port and its logic SHALL be absent; all other behaviour is identical.

Verification
REQ-029 After reset, read_en=1 for one cycle with read_len=0 and mem[0]=0xA5 (replicated):
- data_valid pulses exactly 3 cycles later with weight_a=mem[0].
- Next request reads address 1.
REQ-030 read_len=1, ptr=4, mem[4]=X, mem[5]=Y:
- weight_a=X, weight_b=Y; next ptr=6.
REQ-031 read_en held high for 6 cycles from IDLE:
- Exactly one data_valid in the first 4 cycles.
- A second request is accepted in the cycle after VALID.
REQ-032 BRAM_DEPTH=8, ptr=7, read_len=1:
- Addresses 7 and 0 are read; ptr=1 afterwards.
- addr_wrapped=1 with the macro; no port without it.
REQ-033 address_reset in CAPTURE:
- No data_valid; ptr=0 next cycle; weight_a unchanged.
- A new request returns mem[0].
REQ-034 rst_n pulsed low during ISSUE:
- All outputs 0 immediately; no data_valid after release.
